// File: rtl/mmio_io_bridge.sv
// Memory-mapped I/O bridge: CPU clock-enable, video-RAM window and PS/2 keyboard FIFO registers.
// Reads answer one clk after accept; requests are only taken in cpu_en cycles.
module mmio_io_bridge #(
  parameter int          CLK_DIV   = 2,
  parameter int          KBD_DEPTH = 16,
  parameter int          VRAM_BITS = 13,
  parameter logic [31:0] VRAM_BASE = 32'h0002_0000,
  parameter logic [31:0] KBD_BASE  = 32'hFFFF_FF00
) (
  input  logic                 clk,
  input  logic                 clrn,
  output logic                 cpu_en,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [3:0]           cpu_be,
  input  logic                 cpu_we,
  input  logic                 cpu_re,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_rvalid,
  input  logic [7:0]           kbd_data,
  input  logic                 kbd_valid,
  output logic [VRAM_BITS-1:0] vram_addr,
  output logic [7:0]           vram_wdata,
  output logic                 vram_we,
  input  logic [7:0]           vram_rdata,
  output logic                 irq
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(KBD_DEPTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(KBD_DEPTH);

  // cpu_en is registered off the counter so it is glitch-free and low throughout reset.
  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      div_cnt <= '0;
      cpu_en  <= 1'b0;
    end else begin
      cpu_en  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  logic       wr_acc, rd_acc, vram_hit, kbd_hit, ctrl_wr, flush;
  logic [1:0] kbd_off;

  assign wr_acc   = cpu_en & cpu_we;
  assign rd_acc   = cpu_en & cpu_re & ~cpu_we;
  assign vram_hit = (cpu_addr[31:VRAM_BITS] == VRAM_BASE[31:VRAM_BITS]);
  assign kbd_hit  = (cpu_addr[31:4] == KBD_BASE[31:4]);
  assign kbd_off  = cpu_addr[3:2];
  assign ctrl_wr  = wr_acc & kbd_hit & (kbd_off == 2'd2) & cpu_be[0];
  assign flush    = ctrl_wr & cpu_wdata[1];

  assign vram_addr  = cpu_addr[VRAM_BITS-1:0];
  assign vram_wdata = cpu_wdata[7:0];
  assign vram_we    = wr_acc & vram_hit & cpu_be[0];

  logic [7:0]    kbd_mem [KBD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow, irq_en, nonempty, full, push, pop, drop;

  assign nonempty = (count != '0);
  assign full     = (count == FULL_CNT);
  assign pop      = rd_acc & kbd_hit & (kbd_off == 2'd0) & nonempty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte alongside it.
  assign push     = kbd_valid & (~full | pop) & ~flush;
  assign drop     = kbd_valid & full & ~pop & ~flush;
  assign irq      = irq_en & nonempty;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      irq_en   <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= cpu_wdata[0];
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (drop) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) kbd_mem[wr_ptr] <= kbd_data;
  end

  logic [31:0] status_word, rd_word;

  always_comb begin
    status_word             = '0;
    status_word[0]          = nonempty;
    status_word[1]          = overflow;
    status_word[8 +: AW+1]  = count;
  end

  // Keyboard words are snapshotted at accept so the DATA pop and the returned byte agree.
  always_comb begin
    rd_word = '0;
    if (kbd_hit) begin
      case (kbd_off)
        2'd0:    rd_word = nonempty ? {23'h0, 1'b1, kbd_mem[rd_ptr]} : 32'h0;
        2'd1:    rd_word = status_word;
        2'd2:    rd_word = {30'h0, 1'b0, irq_en};
        default: rd_word = '0;
      endcase
    end
  end

  logic        rsp_vld, rsp_vram;
  logic [31:0] rsp_word;

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rsp_vld  <= 1'b0;
      rsp_vram <= 1'b0;
      rsp_word <= '0;
    end else begin
      rsp_vld  <= rd_acc;
      rsp_vram <= rd_acc & vram_hit;
      rsp_word <= rd_acc ? rd_word : 32'h0;
    end
  end

  assign cpu_rvalid = rsp_vld;
  assign cpu_rdata  = !rsp_vld ? 32'h0 : (rsp_vram ? {24'h0, vram_rdata} : rsp_word);

  logic unused_bits;
  assign unused_bits = ^{cpu_wdata[31:8], cpu_be[3:1]};

endmodule

// File: doc/mmio_io_bridge.md
Name: mmio_io_bridge

Overview:
Parametrised memory-mapped I/O bridge between the rv32i core and its peripherals. It replaces the fixed clock halver and the ad-hoc keyboard/video read mux at machine level. It generates a CPU clock-enable, decodes a video-RAM window and a keyboard register block, and buffers PS/2 scancodes in a FIFO with overflow tracking and an interrupt request. Single clock domain: all peripherals run on clk and are qualified by cpu_en.

Parameters:
CLK_DIV, 2, cpu_en period in clk cycles (>=1; 1 = always enabled)
KBD_DEPTH, 16, keyboard FIFO entries (power of 2, >=2)
VRAM_BITS, 13, video RAM byte-address width (window = 2^VRAM_BITS bytes)
VRAM_BASE, 32'h0002_0000, window base (aligned to 2^VRAM_BITS)
KBD_BASE, 32'hFFFF_FF00, keyboard register block base (16-byte aligned)

Ports:
clk  in  1  system clock
clrn  in  1  reset, synchronous, active-low
cpu_en  out  1  one-cycle clock-enable pulse every CLK_DIV cycles
cpu_addr  in  32  byte address
cpu_wdata  in  32  write data
cpu_be  in  4  byte enables
cpu_we  in  1  write request
cpu_re  in  1  read request
cpu_rdata  out  32  read data, valid when cpu_rvalid=1, else 0
cpu_rvalid  out  1  read response pulse
kbd_data  in  8  scancode from ps2_keyboard
kbd_valid  in  1  one-cycle scancode strobe
vram_addr  out  VRAM_BITS  video RAM address (cpu_addr offset)
vram_wdata  out  8  video RAM write byte (cpu_wdata[7:0])
vram_we  out  1  video RAM write strobe
vram_rdata  in  8  video RAM data, synchronous read (valid one clk after address)
irq  out  1  keyboard interrupt request

Behaviour:
- Every clock edge with clrn=0: divider counter=0, cpu_en=0, FIFO pointers/count=0, overflow=0, irq_en=0, cpu_rvalid=0, cpu_rdata=0. Reset mid-access discards any pending read response.
- Divider: counter 0..CLK_DIV-1; cpu_en=1 in the cycle counter==CLK_DIV-1. First pulse is CLK_DIV cycles after reset release. CLK_DIV=1 gives cpu_en=1 continuously after reset.
- CPU requests are accepted only in cycles with cpu_en=1. If cpu_we and cpu_re are both set, the write is performed and the read is ignored (no rvalid).
- Decode: VRAM hit when cpu_addr[31:VRAM_BITS]==VRAM_BASE[31:VRAM_BITS]. KBD hit when cpu_addr[31:4]==KBD_BASE[31:4]. All other addresses are unmapped.
- VRAM write: vram_we = accepted write & VRAM hit & cpu_be[0], combinational in the same cycle. vram_addr = cpu_addr[VRAM_BITS-1:0] whenever cpu_addr is in the window.
- Read latency is exactly one clk after accept: cpu_rvalid=1 for one cycle, with cpu_rdata per the registered selector:
  - VRAM: {24'h0, vram_rdata}
  - KBD+0 DATA: {23'h0, nonempty, head byte}. Pops if nonempty; empty returns 0.
  - KBD+4 STATUS: {count (zero-extended), 6'h0, overflow, nonempty} with count at bits [8+:$clog2(KBD_DEPTH)+1]
  - KBD+8 CTRL: {30'h0, 1'b0, irq_en}
  - KBD+C or unmapped: 0, rvalid still asserted.
- CTRL write (cpu_be[0]): bit0 -> irq_en; bit1=1 flushes the FIFO and clears overflow (self-clearing). Writes to other KBD offsets and unmapped addresses are ignored.
- FIFO push: kbd_valid while not full stores kbd_data. Push while full drops the byte and sets overflow (sticky).
- Simultaneous push and pop:
  - When full: both occur, count unchanged, no overflow.
  - When empty: the pop returns nonempty=0; the push stores the byte and count becomes 1.
- Flush and kbd_valid in the same cycle: flush wins, byte dropped, overflow stays 0.
- Pointers wrap modulo KBD_DEPTH. count ranges 0..KBD_DEPTH.
- irq = irq_en & nonempty, driven from registers.

Test Plan:
- CLK_DIV=2, release reset -> cpu_en pulses at cycles 2,4,6... after release; all outputs 0 during reset.
- Write 0x41 to VRAM_BASE+0x10 with be=4'h1 on an enable cycle -> vram_we=1, vram_addr=0x10, vram_wdata=0x41 in that cycle. Same with be=4'h0 -> vram_we=0.
- Push 0x1C, 0x32 via kbd_valid; read STATUS -> 0x0000_0201. Read DATA twice -> 0x11C, 0x132. Third read -> 0x0, rvalid=1.
- Push KBD_DEPTH+1 bytes -> STATUS count=KBD_DEPTH, overflow=1. Then a DATA pop with simultaneous kbd_valid while full -> count stays KBD_DEPTH, no byte lost.
- Write CTRL=0x1 with FIFO empty -> irq=0. Push one byte -> irq=1 next cycle. Write CTRL=0x3 -> FIFO empty, overflow=0, irq=0.
- Read unmapped 0x0000_0004 -> rvalid one clk later with rdata=0. Read+write to VRAM in the same enable cycle -> write performed, no rvalid.
